// File: rtl/mux_stream_pkg.sv
// Shared definitions for the round-robin streaming multiplexer:
// selection-mode encoding and the modulo-N pointer increment.
package mux_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Wraps explicitly so non-power-of-two channel counts return to 0.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping to the lowest requester below ptr if none is found.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic             hi_any, lo_any;
  logic [SEL_W-1:0] hi_idx, lo_idx;

  // Two priority scans (upper segment from ptr, lower segment below ptr)
  // stand in for a rotating search without variable-width indexing.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (req[k] && k >= 32'(ptr) && !hi_any) begin
        hi_any = 1'b1;
        hi_idx = SEL_W'(k);
      end
      if (req[k] && k < 32'(ptr) && !lo_any) begin
        lo_any = 1'b1;
        lo_idx = SEL_W'(k);
      end
    end
  end

  always_comb begin
    any     = hi_any | lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
    grant   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      grant[k] = any && (gnt_idx == SEL_W'(k));
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with a registered output stage,
// selectable fixed (external sel) or round-robin channel arbitration.
module mux_rr_stream
  import mux_stream_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  rr_grant, fx_grant, grant;
  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_any, fx_any, grant_any;
  logic             load_en, xfer;
  logic [WIDTH-1:0] gnt_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .grant   (rr_grant),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // An out-of-range sel matches no channel, so fixed mode simply idles.
  always_comb begin
    fx_grant = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      fx_grant[k] = in_valid[k] && (sel == SEL_W'(k));
    end
    fx_any = |fx_grant;
  end

  always_comb begin
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      gnt_idx   = rr_idx;
      grant_any = rr_any;
    end else begin
      grant     = fx_grant;
      gnt_idx   = sel;
      grant_any = fx_any;
    end
    load_en  = ~valid_q | out_ready;
    xfer     = load_en & grant_any & ~rst;
    in_ready = (load_en && !rst) ? grant : '0;
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant[k]) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = gnt_data;
        ch_d   = gnt_idx;
      end
    end
    if (xfer && mode == MODE_RR) begin
      ptr_d = SEL_W'(wrap_inc(32'(rr_idx), N_CH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel streaming multiplexer; next generation of the team's 4:1 combinational mux.
- Adds a valid/ready handshake per input and on the output, a registered output stage, and two selection modes: fixed (external select) and round-robin arbitration.
- Sits between several producer streams and a single consumer, for example several UART/ALU result streams merged onto one bus.

Parameters:
- N_CH, 4, number of input channels (2..16; need not be a power of two)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(N_CH), width of the select and channel-ID fields (derived; do not override)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  N_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_ready  output  N_CH  per-channel ready (one-hot or zero)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel chosen in fixed mode
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  source channel of out_data
- out_valid  output  1  output holds a word
- out_ready  input  1  consumer accepts a word

Behaviour:
- Reset: one clock and one reset (clk, rst); reset is synchronous and active-high. While rst=1 at a rising edge: out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. in_ready is 0 during reset.
- load_en = ~out_valid | out_ready. The output register accepts a new word only when load_en=1.
- Grant is combinational and one-hot; in_ready[k] = load_en & grant[k]. A transfer on channel k occurs when in_valid[k] & in_ready[k].
- Fixed mode:
  - grant[sel] = in_valid[sel]; all other grants are 0.
  - If sel >= N_CH, there is no grant and the block never stalls on it.
- Round-robin mode:
  - Search in_valid from ptr upward, wrapping modulo N_CH. The first asserted channel is granted.
  - After a transfer from channel g, ptr <= (g+1) mod N_CH. The wrap from N_CH-1 goes to 0, including for non-power-of-two N_CH.
  - ptr is unchanged when no transfer occurs.
- Transfer timing: on a transfer edge, out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - If load_en=1 with no transfer, out_valid <= 0.
  - If out_valid=1 and out_ready=0, all outputs hold.
- Latency and throughput: 1 cycle from an input transfer to out_valid. Sustained 1 word/cycle when out_ready stays high.
- Mode or sel changes: take effect on the next grant evaluation (combinational). A word already held in the output register is unaffected. ptr is kept across mode switches and is not updated by fixed-mode transfers.
- Simultaneous events: output drain (out_ready) and new load in the same cycle is a valid back-to-back transfer, with no bubble.
- in_valid deasserting without a transfer: legal, and nothing is captured.
- Reset mid-operation: a held word is discarded, and no in_ready is asserted in the reset cycle.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel and ptr.

Decomposition:
- Package mux_stream_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - helper function for wrap-increment modulo N_CH
- One sub-module, rr_arbiter:
  - parameter N_CH
  - inputs req[N_CH], ptr[SEL_W]
  - outputs grant[N_CH] (one-hot), gnt_idx[SEL_W], any
  - Purely combinational; mux_rr_stream owns ptr and the output register.

Test Plan:
- Reset, default params: hold rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release, the first out_ch=0.
- Fixed mode, sel=2: data ch0..3 = 8'h10, 8'h20, 8'h30, 8'h40; in_valid=4'b1111, out_ready=1 -> every cycle out_data=8'h30, out_ch=2, in_ready=4'b0100. With sel=2 and in_valid[2]=0 -> in_ready=0, and out_valid drops after 1 cycle.
- Round-robin, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, with one word per cycle and no gaps.
- Round-robin, sparse requests: in_valid=4'b1010 -> out_ch alternates 1,3,1,3. Then in_valid=4'b0001 only -> out_ch=0 repeatedly.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> out_data/out_ch stable, in_ready=0, ptr unchanged. Raising out_ready -> the held word drains and the next word loads the same cycle.
- N_CH=3, WIDTH=16, round-robin all valid -> out_ch 0,1,2,0 (wrap at 3). Reset asserted mid-stream while out_valid=1 -> out_valid=0 next cycle and the first grant after release is ch0.
